// File: rtl/weight_stream_ctrl_if.sv
// Handshake, ROM-port and FIFO-port bundle for the weight streaming controller.
// The master side is the controller; the slave side is its environment (ROM, FIFO, host).
interface weight_stream_ctrl_if #(
   parameter int MEM_SIZE   = 64,
   parameter int DATA_WIDTH = 16
);
   localparam int ADDR_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

   logic                  ap_start;
   logic                  ap_idle;
   logic                  ap_done;
   logic                  ap_ready;
   logic [ADDR_W-1:0]     rom_address0;
   logic                  rom_ce0;
   logic [DATA_WIDTH-1:0] rom_q0;
   logic [DATA_WIDTH-1:0] output_V_din;
   logic                  output_V_full_n;
   logic                  output_V_write;

   modport master (
      input  ap_start, rom_q0, output_V_full_n,
      output ap_idle, ap_done, ap_ready, rom_address0, rom_ce0, output_V_din, output_V_write
   );

   modport slave (
      output ap_start, rom_q0, output_V_full_n,
      input  ap_idle, ap_done, ap_ready, rom_address0, rom_ce0, output_V_din, output_V_write
   );
endinterface

// File: rtl/weight_stream_ctrl.sv
// Replays a ROM-resident kernel set NUM_PASSES times into a FIFO, one word per cycle,
// using a 2-entry skid buffer and read credit to ride out arbitrary FIFO backpressure.
module weight_stream_ctrl #(
   parameter int MEM_SIZE   = 64,
   parameter int DATA_WIDTH = 16,
   parameter int NUM_PASSES = 4
) (
   input  logic                 ap_clk,
   input  logic                 ap_rst_n,
   weight_stream_ctrl_if.master bus
);
   localparam int ADDR_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
   localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
   localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_SIZE - 1);
   localparam logic [PASS_W-1:0] PASS_ZERO = PASS_W'(0);
   localparam logic [PASS_W-1:0] PASS_ONE  = PASS_W'(1);
   localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_PASSES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

   logic [1:0]            rst_sync_r;
   logic                  rst_int_n_s;
   state_t                state_r;
   logic [ADDR_W-1:0]     addr_r;
   logic [PASS_W-1:0]     pass_r;
   logic                  idle_r;
   logic                  done_r;
   logic                  rd_valid_r;
   logic [1:0]            cnt_r;
   logic [DATA_WIDTH-1:0] slot0_r;
   logic [DATA_WIDTH-1:0] slot1_r;
   logic                  pop_s;
   logic [2:0]            credit_s;
   logic                  issue_s;
   logic                  last_addr_s;
   logic                  last_pass_s;
   logic                  last_word_s;

   // Reset synchronizer: asserts asynchronously, releases after two clock edges.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         rst_sync_r <= 2'b00;
      end else begin
         rst_sync_r <= {rst_sync_r[0], 1'b1};
      end
   end

   assign rst_int_n_s = rst_sync_r[1];

   // Credit: a read issues only if the slot it will need is guaranteed free on arrival.
   always_comb begin
      pop_s       = (cnt_r != 2'd0) && bus.output_V_full_n;
      credit_s    = {1'b0, cnt_r} + {2'b00, rd_valid_r} - {2'b00, pop_s};
      issue_s     = (state_r == ST_RUN) && (credit_s < 3'd2);
      last_addr_s = (addr_r == ADDR_LAST);
      last_pass_s = (pass_r == PASS_LAST);
      last_word_s = pop_s && (cnt_r == 2'd1) && !rd_valid_r;
   end

   // Sequencing FSM with address/pass counters and registered status outputs.
   always_ff @(posedge ap_clk or negedge rst_int_n_s) begin
      if (!rst_int_n_s) begin
         state_r <= ST_IDLE;
         addr_r  <= ADDR_ZERO;
         pass_r  <= PASS_ZERO;
         idle_r  <= 1'b1;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.ap_start) begin
                  state_r <= ST_RUN;
                  idle_r  <= 1'b0;
                  addr_r  <= ADDR_ZERO;
                  pass_r  <= PASS_ZERO;
               end
            end
            ST_RUN: begin
               if (issue_s) begin
                  if (last_addr_s) begin
                     addr_r <= ADDR_ZERO;
                     if (last_pass_s) begin
                        pass_r  <= PASS_ZERO;
                        state_r <= ST_DRAIN;
                     end else begin
                        pass_r <= pass_r + PASS_ONE;
                     end
                  end else begin
                     addr_r <= addr_r + ADDR_ONE;
                  end
               end
            end
            ST_DRAIN: begin
               if (last_word_s) begin
                  state_r <= ST_DONE;
                  done_r  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               done_r  <= 1'b0;
               idle_r  <= 1'b1;
            end
            default: begin
               state_r <= ST_IDLE;
               done_r  <= 1'b0;
               idle_r  <= 1'b1;
            end
         endcase
      end
   end

   // Skid buffer: slot0 is the head; ROM data is captured the cycle it is valid.
   always_ff @(posedge ap_clk or negedge rst_int_n_s) begin
      if (!rst_int_n_s) begin
         rd_valid_r <= 1'b0;
         cnt_r      <= 2'd0;
         slot0_r    <= {DATA_WIDTH{1'b0}};
         slot1_r    <= {DATA_WIDTH{1'b0}};
      end else begin
         rd_valid_r <= issue_s;
         case ({rd_valid_r, pop_s})
            2'b11: begin
               if (cnt_r == 2'd2) begin
                  slot0_r <= slot1_r;
                  slot1_r <= bus.rom_q0;
               end else begin
                  slot0_r <= bus.rom_q0;
               end
            end
            2'b10: begin
               if (cnt_r == 2'd0) begin
                  slot0_r <= bus.rom_q0;
               end else begin
                  slot1_r <= bus.rom_q0;
               end
               cnt_r <= cnt_r + 2'd1;
            end
            2'b01: begin
               slot0_r <= slot1_r;
               cnt_r   <= cnt_r - 2'd1;
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   assign bus.rom_ce0        = issue_s;
   assign bus.rom_address0   = addr_r;
   assign bus.output_V_write = pop_s;
   assign bus.output_V_din   = slot0_r;
   assign bus.ap_idle        = idle_r;
   assign bus.ap_done        = done_r;
   assign bus.ap_ready       = done_r;
endmodule
